ahb_lite_master_if: RTL and testbench

//  CPU-side AHB-Lite initiator: turns core load/store requests into single AHB-Lite transfers.

---
 rtl/ahb_lite_master_if_if.sv | 40 ++++
 rtl/ahb_lite_master_if.sv | 122 ++++++++++++
 tb/tb_ahb_lite_master_if.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_master_if_if.sv
// Core request/response and AHB-Lite master signals of the load/store initiator.
// The master modport is the initiator's view; the slave modport is the core plus bus fabric.
interface ahb_lite_master_if_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [1:0]        cpu_size;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic              cpu_done;
  logic              cpu_err;
  logic [DATA_W-1:0] cpu_rdata;

  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [DATA_W-1:0] HWDATA;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADY;
  logic              HRESP;

  modport master (
    input  cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
    output cpu_ready, cpu_done, cpu_err, cpu_rdata,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    output cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
    input  cpu_ready, cpu_done, cpu_err, cpu_rdata,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_lite_master_if.sv
// Single-outstanding AHB-Lite initiator for core loads/stores; done 3 cycles after accept with a zero-wait slave.
// Core handshake is ready/req (requests while busy are dropped); bus backpressure is HREADY, each wait adds a cycle.
module ahb_lite_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  ahb_lite_master_if_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_ERR  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [2:0]        size_q, size_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [2:0] req_hsize;
  logic       req_misaligned;

  // Size 2'b11 is folded into word before it reaches the bus or the alignment check.
  always_comb begin
    req_hsize      = (bus.cpu_size == 2'b11) ? 3'b010 : {1'b0, bus.cpu_size};
    req_misaligned = 1'b0;
    case (req_hsize)
      3'b001:  req_misaligned = bus.cpu_addr[0];
      3'b010:  req_misaligned = (bus.cpu_addr[1:0] != 2'b00);
      default: req_misaligned = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= 3'b000;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req) begin
          addr_d  = bus.cpu_addr;
          we_d    = bus.cpu_we;
          size_d  = req_hsize;
          wdata_d = bus.cpu_wdata;
          err_d   = req_misaligned;
          state_d = req_misaligned ? S_RESP : S_ADDR;
        end
      end
      S_ADDR: begin
        if (bus.HREADY) state_d = S_DATA;
      end
      S_DATA: begin
        if (bus.HREADY) begin
          // A one-cycle ERROR from a non-compliant slave is still reported as an error.
          err_d   = bus.HRESP;
          state_d = S_RESP;
          if (!bus.HRESP && !we_q) rdata_d = bus.HRDATA;
        end else if (bus.HRESP) begin
          state_d = S_ERR;
        end
      end
      S_ERR: begin
        if (bus.HREADY) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.HTRANS    = (state_q == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    bus.HADDR     = addr_q;
    bus.HWRITE    = we_q;
    bus.HSIZE     = size_q;
    bus.HBURST    = 3'b000;
    bus.HWDATA    = '0;
    if ((state_q == S_DATA || state_q == S_ERR) && we_q) bus.HWDATA = wdata_q;
    bus.cpu_ready = (state_q == S_IDLE);
    bus.cpu_done  = (state_q == S_RESP);
    bus.cpu_err   = (state_q == S_RESP) && err_q;
    bus.cpu_rdata = rdata_q;
  end

endmodule

// File: tb/tb_ahb_lite_master_if.sv
// Randomized bench: a planned-response AHB slave, a transaction-level model and a done-pulse scoreboard.
module tb_ahb_lite_master_if;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [2:0]  hsize;
    logic [31:0] wdata;
    int          stalls;
    int          waits;
    bit          err;
    logic [31:0] rdata;
  } plan_t;

  typedef struct {
    bit          err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc = 0;
  bit   rst_seen = 1'b1;
  int   checks = 0;
  int   failures = 0;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  int    busy_until = 0;
  logic [31:0] last_pred = 32'h0;
  logic [31:0] held = 32'h0;

  plan_t cur;
  bit    addr_act = 1'b0;
  bit    dp_act = 1'b0;
  bit    err_stage = 1'b0;
  int    stall_left = 0;
  int    wait_left = 0;

  ahb_lite_master_if_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ahb_lite_master_if #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= !reset;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Holds cpu_req high with these fields until the model predicts acceptance.
  task automatic issue(input bit we, input logic [1:0] sz, input logic [31:0] addr,
                       input logic [31:0] wd, input int stalls, input int waits,
                       input bit err, input logic [31:0] rd, input bit drop);
    int    guard = 0;
    bit    accepted = 1'b0;
    bit    mis;
    plan_t p;
    exp_t  e;
    while (!accepted) begin
      @(negedge clk);
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = we;
      bus.cpu_size  = sz;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wd;
      check("cpu_ready", {63'd0, bus.cpu_ready}, {63'd0, (cyc > busy_until)});
      if (cyc > busy_until) begin
        accepted = 1'b1;
        mis = (sz == 2'b01) ? addr[0] : (sz[1] ? (addr[1:0] != 2'b00) : 1'b0);
        if (mis) begin
          e.err   = 1'b1;
          e.rdata = last_pred;
          e.cyc   = cyc + 1;
        end else begin
          p.addr   = addr;
          p.we     = we;
          p.hsize  = (sz == 2'b11) ? 3'd2 : {1'b0, sz};
          p.wdata  = wd;
          p.stalls = stalls;
          p.waits  = waits;
          p.err    = err;
          p.rdata  = rd;
          plan_q.push_back(p);
          e.err   = err;
          e.rdata = (err || we) ? last_pred : rd;
          e.cyc   = cyc + 3 + stalls + waits + (err ? 1 : 0);
        end
        exp_q.push_back(e);
        busy_until = e.cyc;
        last_pred  = e.rdata;
      end else if (++guard > 100) begin
        check("accept_timeout", 64'd1, 64'd0);
        accepted = 1'b1;
      end
    end
    if (drop) begin
      @(negedge clk);
      bus.cpu_req = 1'b0;
    end
  endtask

  // Scoreboard / protocol monitor.
  always @(negedge clk) begin
    exp_t e;
    if (rst_seen) held = 32'h0;
    if (bus.cpu_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("cpu_err", {63'd0, bus.cpu_err}, {63'd0, e.err});
        check("cpu_rdata", {32'd0, bus.cpu_rdata}, {32'd0, e.rdata});
        check("done_cycle", 64'(cyc), 64'(e.cyc));
        held = e.rdata;
      end
    end else begin
      check("err_without_done", {63'd0, bus.cpu_err}, 64'd0);
      check("rdata_held", {32'd0, bus.cpu_rdata}, {32'd0, held});
    end
    check("hburst", {61'd0, bus.HBURST}, 64'd0);
    if (bus.HTRANS !== 2'b00 && bus.HTRANS !== 2'b10)
      check("htrans_legal", {62'd0, bus.HTRANS}, 64'd0);
  end

  // Slave: follows the per-transfer plan queued by the stimulus.
  initial begin
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    bus.HRDATA = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        addr_act   = 1'b0;
        dp_act     = 1'b0;
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
      end else if (dp_act) begin
        check("hwdata", {32'd0, bus.HWDATA}, {32'd0, (cur.we ? cur.wdata : 32'h0)});
        check("htrans_in_data", {62'd0, bus.HTRANS}, 64'd0);
        bus.HRDATA = $urandom;
        if (wait_left > 0) begin
          bus.HREADY = 1'b0;
          bus.HRESP  = 1'b0;
          wait_left--;
        end else if (cur.err) begin
          bus.HRESP = 1'b1;
          if (!err_stage) begin
            bus.HREADY = 1'b0;
            err_stage  = 1'b1;
          end else begin
            bus.HREADY = 1'b1;
            dp_act     = 1'b0;
          end
        end else begin
          bus.HREADY = 1'b1;
          bus.HRESP  = 1'b0;
          bus.HRDATA = cur.rdata;
          dp_act     = 1'b0;
        end
      end else if (bus.HTRANS == 2'b10) begin
        bus.HRESP = 1'b0;
        if (!addr_act) begin
          if (plan_q.size() == 0) begin
            check("unexpected_nonseq", 64'd1, 64'd0);
          end else begin
            cur        = plan_q.pop_front();
            addr_act   = 1'b1;
            stall_left = cur.stalls;
          end
        end
        bus.HREADY = 1'b1;
        if (addr_act) begin
          check("haddr", {32'd0, bus.HADDR}, {32'd0, cur.addr});
          check("hwrite", {63'd0, bus.HWRITE}, {63'd0, cur.we});
          check("hsize", {61'd0, bus.HSIZE}, {61'd0, cur.hsize});
          if (stall_left > 0) begin
            bus.HREADY = 1'b0;
            stall_left--;
          end else begin
            addr_act  = 1'b0;
            dp_act    = 1'b1;
            wait_left = cur.waits;
            err_stage = 1'b0;
          end
        end
      end else begin
        if (addr_act) check("htrans_dropped", 64'd1, 64'd0);
        addr_act   = 1'b0;
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        bus.HRDATA = $urandom;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the bench finished");
    $fatal(1);
  end

  initial begin
    int guard;
    logic [1:0]  sz;
    logic [31:0] a;
    reset         = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_size  = 2'b00;
    bus.cpu_addr  = 32'h0;
    bus.cpu_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_htrans", {62'd0, bus.HTRANS}, 64'd0);
    check("rst_haddr", {32'd0, bus.HADDR}, 64'd0);
    check("rst_hwrite", {63'd0, bus.HWRITE}, 64'd0);
    check("rst_hsize", {61'd0, bus.HSIZE}, 64'd0);
    check("rst_hwdata", {32'd0, bus.HWDATA}, 64'd0);
    check("rst_cpu_done", {63'd0, bus.cpu_done}, 64'd0);
    check("rst_cpu_err", {63'd0, bus.cpu_err}, 64'd0);
    check("rst_cpu_rdata", {32'd0, bus.cpu_rdata}, 64'd0);
    check("rst_cpu_ready", {63'd0, bus.cpu_ready}, 64'd1);
    reset      = 1'b1;
    busy_until = cyc;

    issue(1'b1, 2'b10, 32'h100, 32'hDEADBEEF, 0, 0, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 2'b10, 32'h100, 32'h0, 0, 2, 1'b0, 32'hDEADBEEF, 1'b1);
    issue(1'b0, 2'b10, 32'h104, 32'h0, 0, 0, 1'b1, 32'h12345678, 1'b1);
    issue(1'b0, 2'b10, 32'h102, 32'h0, 0, 0, 1'b0, 32'h0, 1'b1);
    issue(1'b1, 2'b01, 32'h101, 32'h5555AAAA, 0, 0, 1'b0, 32'h0, 1'b1);
    issue(1'b1, 2'b00, 32'h103, 32'h00AB0000, 1, 1, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 2'b11, 32'h108, 32'h0, 2, 0, 1'b0, 32'hCAFEF00D, 1'b1);

    // Back-to-back reads with cpu_req never dropped.
    issue(1'b0, 2'b10, 32'h200, 32'h0, 0, 0, 1'b0, 32'h11111111, 1'b0);
    issue(1'b0, 2'b10, 32'h204, 32'h0, 0, 0, 1'b0, 32'h22222222, 1'b0);
    issue(1'b0, 2'b10, 32'h208, 32'h0, 0, 0, 1'b0, 32'h33333333, 1'b1);

    // Reset during a data-phase wait state abandons the transfer.
    issue(1'b0, 2'b10, 32'h300, 32'h0, 0, 6, 1'b0, 32'h44444444, 1'b1);
    repeat (2) @(negedge clk);
    reset       = 1'b0;
    bus.cpu_req = 1'b0;
    exp_q.delete();
    plan_q.delete();
    last_pred  = 32'h0;
    busy_until = cyc;
    @(negedge clk);
    reset = 1'b1;
    check("midrst_htrans", {62'd0, bus.HTRANS}, 64'd0);
    check("midrst_ready", {63'd0, bus.cpu_ready}, 64'd1);
    check("midrst_done", {63'd0, bus.cpu_done}, 64'd0);
    issue(1'b0, 2'b10, 32'h300, 32'h0, 0, 0, 1'b0, 32'h55555555, 1'b1);

    for (int i = 0; i < 40; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
      issue(1'($urandom_range(0, 1)), sz, a, $urandom, $urandom_range(0, 2),
            $urandom_range(0, 3), ($urandom_range(0, 4) == 0), $urandom,
            1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    bus.cpu_req = 1'b0;

    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    check("plan_consumed", 64'(plan_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
